// File: rtl/i2c_config_sequencer_pkg.sv
// i2c_cfg_pkg: shared types and the default configuration table for the
// I2C configuration sequencer.
//   state_t      - sequencer FSM states (fixed legacy encodings)
//   cfg_entry_t  - 23-bit table entry {dev[22:16], reg[15:8], data[7:0]}
//   CFG_TABLE    - default board register-write table
//   cfg_lookup   - table read; indices past the table return all-zero
package i2c_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd6
    } state_t;

    typedef struct packed {
        logic [6:0] dev;
        logic [7:0] rgst;
        logic [7:0] data;
    } cfg_entry_t;

    localparam int unsigned CFG_DEPTH = 8;
    localparam int unsigned CFG_AW    = 3;

    localparam cfg_entry_t CFG_TABLE [CFG_DEPTH] = '{
        '{dev: 7'h48, rgst: 8'h47, data: 8'h02},  // DAC: mode, channel 1
        '{dev: 7'h48, rgst: 8'h01, data: 8'h10},  // DAC: output range
        '{dev: 7'h1A, rgst: 8'h00, data: 8'h80},  // codec: soft reset release
        '{dev: 7'h1A, rgst: 8'h02, data: 8'h33},  // codec: clock config
        '{dev: 7'h50, rgst: 8'h10, data: 8'hA5},  // PMIC: rail enable
        '{dev: 7'h50, rgst: 8'h11, data: 8'h5A},  // PMIC: rail voltage
        '{dev: 7'h48, rgst: 8'h40, data: 8'h01},  // DAC: power up
        '{dev: 7'h48, rgst: 8'h47, data: 8'h03}   // DAC: mode, channels 1+2
    };

    function automatic cfg_entry_t cfg_lookup(input logic [7:0] i);
        cfg_entry_t e;
        e = '0;
        for (int unsigned k = 0; k < CFG_DEPTH; k++) begin
            if (i == 8'(k)) e = CFG_TABLE[k[CFG_AW-1:0]];
        end
        return e;
    endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// Command/response bus between the configuration sequencer and the
// byte-level I2C write master.
//   cmd_valid/cmd_ready - command handshake (sequencer -> master)
//   cmd_dev/reg/data    - 7-bit device, register address, write data
//   rsp_valid/rsp_nack  - one-cycle completion pulse, NACK qualifier
// Modports: master = sequencer side, slave = I2C master side.
interface i2c_config_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_nack;

    modport master (
        output cmd_valid, cmd_dev, cmd_reg, cmd_data,
        input  cmd_ready, rsp_valid, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
        output cmd_ready, rsp_valid, rsp_nack
    );
endinterface

// File: rtl/i2c_config_sequencer_rom.sv
// i2c_cfg_rom: registered lookup into CFG_TABLE; entry appears one clock
// after addr. Entries at or beyond N_CMDS read as zero.
//   clk, rst_n - clock, async active-low reset
//   addr       - entry index
//   entry      - registered table entry
module i2c_cfg_rom
    import i2c_cfg_pkg::*;
#(
    parameter int N_CMDS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    output cfg_entry_t entry
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
        end else if (int'(addr) < N_CMDS) begin
            entry <= cfg_lookup(addr);
        end else begin
            entry <= '0;
        end
    end

endmodule

// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks the configuration table and issues each
// register write to the I2C master, retrying on NACK/timeout and spacing
// transactions by GAP_CYCLES.
//   clk, rst_n - clock, async active-low reset
//   start      - single-cycle run request (sampled only in IDLE)
//   busy       - run in progress
//   done       - one-cycle pulse, every entry ACKed
//   error      - sticky failure flag, cleared by the next accepted start
//   err_idx    - index of the failing entry
//   bus        - command/response bus to the I2C master
module i2c_config_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int N_CMDS         = 8,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRY      = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [7:0]             err_idx,
    i2c_config_sequencer_if.master bus
);

    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       IDX_LAST   = 8'(N_CMDS - 1);
    localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRY);

    state_t           state;
    logic [7:0]       idx;
    logic [3:0]       retry;
    logic [CNT_W-1:0] cnt;
    cfg_entry_t       entry_q;
    cfg_entry_t       rom_entry;
    logic [7:0]       rom_addr;

    // idx still holds the previous run's last index while IDLE, so the ROM
    // is pointed at entry 0 there; the read then lands in time for FETCH.
    assign rom_addr = (state == ST_IDLE) ? '0 : idx;

    i2c_cfg_rom #(
        .N_CMDS(N_CMDS)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (rom_addr),
        .entry (rom_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            retry   <= '0;
            cnt     <= '0;
            error   <= 1'b0;
            err_idx <= '0;
            entry_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        retry   <= '0;
                        error   <= 1'b0;
                        err_idx <= '0;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    entry_q <= rom_entry;
                    state   <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (bus.cmd_ready) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (bus.rsp_valid && !bus.rsp_nack) begin
                        cnt   <= '0;
                        retry <= '0;
                        if (idx == IDX_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= ST_GAP;
                        end
                    end else if (bus.rsp_valid || cnt == TO_LAST) begin
                        cnt <= '0;
                        // error is raised on entry to FAIL so it is visible
                        // in the cycle right after the failing outcome.
                        if (retry == RETRY_LAST) begin
                            error   <= 1'b1;
                            err_idx <= idx;
                            state   <= ST_FAIL;
                        end else begin
                            retry <= retry + 4'd1;
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= ST_FETCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE, ST_FAIL: state <= ST_IDLE;
                default:          state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign bus.cmd_valid = (state == ST_ISSUE);
    assign bus.cmd_dev  = entry_q.dev;
    assign bus.cmd_reg  = entry_q.rgst;
    assign bus.cmd_data = entry_q.data;

endmodule
